// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: req/ack data-memory port between the MEM stage and data memory
interface mem_access_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  modport master (output dm_req, dm_we, dm_addr, dm_wdata, input dm_rdata, dm_ack);
  modport slave  (input dm_req, dm_we, dm_addr, dm_wdata, output dm_rdata, dm_ack);
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage and MEM/WB register with variable-latency memory and error detection
module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                regwr_in,
  input  logic                memwr_in,
  input  logic                memread_in,
  input  logic                memtoreg_in,
  input  logic [4:0]          rd_in,
  input  logic [31:0]         result_in,
  input  logic [31:0]         busb_in,
  output logic                stall_out,
  mem_access_stage_if.master  dm,
  output logic                wb_regwr,
  output logic [4:0]          wb_rd,
  output logic [31:0]         wb_data,
  output logic                align_err,
  output logic                bus_err,
  output logic [31:0]         err_addr
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state, next_state;
  logic [CNT_W-1:0] cnt;
  logic memop, aligned, issue, timeout;
  logic l_regwr, l_m2r;
  logic [4:0] l_rd;
  always_comb begin
    memop      = memread_in | memwr_in;
    aligned    = result_in[1:0] == 2'b00;
    timeout    = cnt == CNT_W'(TIMEOUT - 1);
    issue      = (state == S_IDLE) & memop & aligned;
    // gated by rst so the pipeline is released the instant reset hits
    stall_out  = !rst & ((state == S_IDLE) ? issue : (!dm.dm_ack & !timeout));
    next_state = (state == S_IDLE) ? (issue ? S_WAIT : S_IDLE)
                                   : ((dm.dm_ack | timeout) ? S_IDLE : S_WAIT);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      dm.dm_req   <= 1'b0;
      dm.dm_we    <= 1'b0;
      dm.dm_addr  <= '0;
      dm.dm_wdata <= '0;
      l_regwr     <= 1'b0;
      l_m2r       <= 1'b0;
      l_rd        <= '0;
      wb_regwr    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      align_err   <= 1'b0;
      bus_err     <= 1'b0;
      err_addr    <= '0;
    end else begin
      align_err <= 1'b0;
      bus_err   <= 1'b0;
      wb_regwr  <= 1'b0;
      if (state == S_IDLE) begin
        if (!memop) begin
          wb_regwr <= regwr_in;
          wb_rd    <= rd_in;
          wb_data  <= result_in;
        end else if (aligned) begin
          dm.dm_req   <= 1'b1;
          dm.dm_we    <= memwr_in;
          dm.dm_addr  <= result_in;
          dm.dm_wdata <= busb_in;
          l_regwr     <= regwr_in & !memwr_in;
          l_rd        <= rd_in;
          l_m2r       <= memtoreg_in;
          cnt         <= '0;
        end else begin
          align_err <= 1'b1;
          err_addr  <= result_in;
        end
      end else if (dm.dm_ack) begin
        dm.dm_req <= 1'b0;
        wb_regwr  <= l_regwr;
        wb_rd     <= l_rd;
        wb_data   <= l_m2r ? dm.dm_rdata : dm.dm_addr;
      end else if (timeout) begin
        dm.dm_req <= 1'b0;
        bus_err   <= 1'b1;
        err_addr  <= dm.dm_addr;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: transaction-level model driven by directed and random instruction streams
module tb_mem_access_stage;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic regwr_in = 0, memwr_in = 0, memread_in = 0, memtoreg_in = 0;
  logic [4:0] rd_in = '0;
  logic [31:0] result_in = '0, busb_in = '0;
  logic stall_out, wb_regwr, align_err, bus_err;
  logic [4:0] wb_rd;
  logic [31:0] wb_data, err_addr;
  mem_access_stage_if dmif();
  mem_access_stage #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .regwr_in(regwr_in), .memwr_in(memwr_in), .memread_in(memread_in),
    .memtoreg_in(memtoreg_in), .rd_in(rd_in), .result_in(result_in), .busb_in(busb_in),
    .stall_out(stall_out), .dm(dmif), .wb_regwr(wb_regwr), .wb_rd(wb_rd), .wb_data(wb_data),
    .align_err(align_err), .bus_err(bus_err), .err_addr(err_addr)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  bit chk_en = 0;
  logic exp_stall, exp_req, exp_we, exp_wbregwr, exp_aerr, exp_berr;
  logic [4:0] exp_wbrd;
  logic [31:0] exp_addr, exp_wdata, exp_wbdata, exp_eaddr;
  logic nxt_req, nxt_we, nxt_wbregwr, nxt_aerr, nxt_berr;
  logic [4:0] nxt_wbrd;
  logic [31:0] nxt_addr, nxt_wdata, nxt_wbdata, nxt_eaddr;
  bit lit_on = 0, lit_wbregwr, lit_aerr, lit_berr;
  logic [4:0] lit_wbrd;
  logic [31:0] lit_wbdata, lit_eaddr;
  int req_cnt, stall_cnt;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("stall_out", stall_out, exp_stall);
    chk("dm_req", dmif.dm_req, exp_req);
    chk("dm_we", dmif.dm_we, exp_we);
    chk("dm_addr", dmif.dm_addr, exp_addr);
    chk("dm_wdata", dmif.dm_wdata, exp_wdata);
    chk("wb_regwr", wb_regwr, exp_wbregwr);
    if (exp_wbregwr) begin
      chk("wb_rd", wb_rd, exp_wbrd);
      chk("wb_data", wb_data, exp_wbdata);
    end
    chk("align_err", align_err, exp_aerr);
    chk("bus_err", bus_err, exp_berr);
    chk("err_addr", err_addr, exp_eaddr);
  end
  task automatic model_clear();
    {exp_stall, exp_req, exp_we, exp_wbregwr, exp_aerr, exp_berr} = '0;
    {exp_wbrd, exp_addr, exp_wdata, exp_wbdata, exp_eaddr} = '0;
    {nxt_req, nxt_we, nxt_wbregwr, nxt_aerr, nxt_berr} = '0;
    {nxt_wbrd, nxt_addr, nxt_wdata, nxt_wbdata, nxt_eaddr} = '0;
  endtask
  // advance one clock; registered expectations take the values scheduled last cycle
  task automatic cyc();
    @(posedge clk);
    #1;
    exp_req = nxt_req; exp_we = nxt_we; exp_addr = nxt_addr; exp_wdata = nxt_wdata;
    exp_wbregwr = nxt_wbregwr; exp_wbrd = nxt_wbrd; exp_wbdata = nxt_wbdata;
    exp_aerr = nxt_aerr; exp_berr = nxt_berr; exp_eaddr = nxt_eaddr;
    nxt_aerr = 0; nxt_berr = 0; nxt_wbregwr = 0;
    if (lit_on) begin
      chk("lit_wb_regwr", wb_regwr, lit_wbregwr);
      if (lit_wbregwr) begin
        chk("lit_wb_rd", wb_rd, lit_wbrd);
        chk("lit_wb_data", wb_data, lit_wbdata);
      end
      chk("lit_align_err", align_err, lit_aerr);
      chk("lit_bus_err", bus_err, lit_berr);
      chk("lit_err_addr", err_addr, lit_eaddr);
      lit_on = 0;
    end
  endtask
  task automatic lit(input bit r, input logic [4:0] rd, input logic [31:0] d, input bit a, input bit b,
                     input logic [31:0] e);
    lit_wbregwr = r; lit_wbrd = rd; lit_wbdata = d; lit_aerr = a; lit_berr = b; lit_eaddr = e; lit_on = 1;
  endtask
  // one instruction from EX/MEM; dly = WAIT cycle carrying the ack (0 = never acked)
  task automatic run_instr(input bit regwr, input bit memwr, input bit memread, input bit m2r,
                           input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] wdata,
                           input int dly, input logic [31:0] rdata);
    bit memop, aligned;
    cyc();
    regwr_in = regwr; memwr_in = memwr; memread_in = memread; memtoreg_in = m2r;
    rd_in = rd; result_in = addr; busb_in = wdata;
    dmif.dm_ack = 1'($urandom % 2);
    dmif.dm_rdata = $urandom;
    memop = memwr | memread;
    aligned = addr[1:0] == 2'b00;
    req_cnt = 0; stall_cnt = 0;
    exp_stall = memop && aligned;
    if (!memop) begin
      nxt_wbregwr = regwr; nxt_wbrd = rd; nxt_wbdata = addr;
    end else if (!aligned) begin
      nxt_aerr = 1; nxt_eaddr = addr;
    end else begin
      nxt_req = 1; nxt_we = memwr; nxt_addr = addr; nxt_wdata = wdata;
    end
    #1;
    stall_cnt += int'(stall_out);
    if (memop && aligned) begin
      for (int k = 1; k <= TO; k++) begin
        cyc();
        dmif.dm_ack = (k == dly);
        dmif.dm_rdata = (k == dly) ? rdata : $urandom;
        exp_stall = (k != dly) && (k < TO);
        if (k == dly) begin
          nxt_req = 0; nxt_wbregwr = regwr && !memwr; nxt_wbrd = rd;
          nxt_wbdata = m2r ? rdata : addr;
        end else if (k == TO) begin
          nxt_req = 0; nxt_berr = 1; nxt_eaddr = addr;
        end
        #1;
        req_cnt += int'(dmif.dm_req);
        stall_cnt += int'(stall_out);
        if (k == dly || k == TO) break;
      end
    end
  endtask
  initial begin
    logic [31:0] a;
    int t, d;
    bit w, r;
    model_clear();
    dmif.dm_ack = 0; dmif.dm_rdata = '0;
    chk_en = 1;
    @(posedge clk); #1 rst = 0;
    run_instr(1, 0, 0, 0, 5, 32'h1234, 0, 0, 0);
    chk("alu_stall_cnt", stall_cnt, 0);
    lit(1, 5, 32'h1234, 0, 0, 0);
    run_instr(1, 0, 1, 1, 7, 32'h100, 0, 3, 32'hDEADBEEF);
    chk("load_req_cnt", req_cnt, 3);
    chk("load_stall_cnt", stall_cnt, 3);
    chk("load_dm_addr", dmif.dm_addr, 32'h100);
    lit(1, 7, 32'hDEADBEEF, 0, 0, 0);
    run_instr(1, 1, 0, 0, 9, 32'h200, 32'hCAFEF00D, 1, 32'h0);
    chk("store_stall_cnt", stall_cnt, 1);
    chk("store_dm_wdata", dmif.dm_wdata, 32'hCAFEF00D);
    chk("store_dm_we", dmif.dm_we, 1);
    lit(0, 0, 0, 0, 0, 0);
    run_instr(1, 0, 1, 1, 3, 32'h102, 0, 2, 0);
    chk("misalign_stall_cnt", stall_cnt, 0);
    lit(0, 0, 0, 1, 0, 32'h102);
    run_instr(1, 0, 1, 1, 4, 32'h300, 0, 0, 0);
    chk("timeout_req_cnt", req_cnt, 16);
    chk("timeout_stall_cnt", stall_cnt, 16);
    lit(0, 0, 0, 0, 1, 32'h300);
    run_instr(1, 0, 1, 1, 4, 32'h304, 0, 16, 32'h5A5A);
    chk("ack16_req_cnt", req_cnt, 16);
    lit(1, 4, 32'h5A5A, 0, 0, 32'h300);
    run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // reset in the middle of an outstanding load
    run_instr(1, 0, 1, 1, 6, 32'h400, 32'h11, 0, 0);
    cyc(); dmif.dm_ack = 0; regwr_in = 1; memread_in = 1; memtoreg_in = 1; rd_in = 6; result_in = 32'h400;
    exp_stall = 1; nxt_req = 1; nxt_we = 0; nxt_addr = 32'h400; nxt_wdata = 32'h11;
    cyc(); exp_stall = 1;
    cyc(); exp_stall = 1;
    #2 chk_en = 0; rst = 1;
    #1;
    chk("rst_dm_req", dmif.dm_req, 0);
    chk("rst_stall", stall_out, 0);
    chk("rst_wb_regwr", wb_regwr, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_dm_addr", dmif.dm_addr, 0);
    model_clear();
    regwr_in = 0; memwr_in = 0; memread_in = 0; memtoreg_in = 0; rd_in = 0; result_in = 0; busb_in = 0;
    dmif.dm_ack = 0;
    @(negedge clk); chk_en = 1;
    @(posedge clk); #1 rst = 0;
    run_instr(1, 0, 0, 0, 12, 32'hABCD, 0, 0, 0);
    lit(1, 12, 32'hABCD, 0, 0, 0);
    repeat (250) begin
      t = int'($urandom % 10);
      w = 1'($urandom % 2);
      r = w ? 1'($urandom % 2) : 1'b1;
      d = int'($urandom % 8);
      d = (d == 0) ? 0 : (d == 1) ? TO : int'($urandom_range(1, 5));
      a = $urandom & ~32'h3;
      if (t < 4)
        run_instr(1'($urandom % 2), 0, 0, 1'($urandom % 2), 5'($urandom), $urandom, $urandom, 0, 0);
      else if (t == 4)
        run_instr(1'($urandom % 2), w, r, 1'($urandom % 2), 5'($urandom), a | 32'($urandom_range(1, 3)),
                  $urandom, d, $urandom);
      else
        run_instr(1'($urandom % 2), w, r, 1'($urandom % 2), 5'($urandom), a, $urandom, d, $urandom);
    end
    cyc();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
